// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer.
// One operation at a time. A multiply is done by shift-add and a divide
// by restoring division, one bit per cycle over XLEN cycles, on operand
// magnitudes. The sign is fixed up afterwards and the result is held.
// States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
// If FAST_SPECIAL=1, divide-by-zero and signed-overflow divides go
// straight from PREP to DONE.
module mdu_seq #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PREP = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  // Result of a special-case divide.
  // Divide by zero: quotient is all ones and the remainder is the dividend.
  // Signed overflow: quotient is the dividend and the remainder is zero.
  function automatic logic [XLEN-1:0] special_result(
    input logic            is_rem,
    input logic            by_zero,
    input logic [XLEN-1:0] dividend
  );
    logic [XLEN-1:0] r;
    if (by_zero) begin
      r = is_rem ? dividend : ALL_ONES;
    end else begin
      r = is_rem ? ZERO_X : dividend;
    end
    return r;
  endfunction

  // Registered state and datapath
  logic [2:0]        state_q,   state_d;
  logic [2:0]        func3_q,   func3_d;
  logic [XLEN-1:0]   a_q,       a_d;
  logic [XLEN-1:0]   b_q,       b_d;
  logic              neg_a_q,   neg_a_d;
  logic              neg_b_q,   neg_b_d;
  logic [XLEN-1:0]   mcand_q,   mcand_d;   // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q,     acc_d;     // hi:lo = product:multiplier or rem:quot
  logic [CW-1:0]     cnt_q,     cnt_d;
  logic [XLEN-1:0]   result_q,  result_d;
  logic              done_q,    done_d;
  logic              busy_q,    busy_d;

  // Combinational helpers
  logic              is_div_s;
  logic              a_signed_s;
  logic              b_signed_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic              special_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN-1:0] mul_next_s;
  logic [XLEN:0]     rem_sh_s;
  logic [XLEN-1:0]   div_sub_s;
  logic              div_ge_s;
  logic [2*XLEN-1:0] div_next_s;
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quot_fix_s;
  logic [XLEN-1:0]   rem_fix_s;
  logic [XLEN-1:0]   fix_res_s;

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

  // Decode the latched operation: signedness, special divides, magnitudes
  always_comb begin
    is_div_s   = func3_q[2];
    a_signed_s = (func3_q == 3'b001) || (func3_q == 3'b010) ||
                 (func3_q == 3'b100) || (func3_q == 3'b110);
    b_signed_s = (func3_q == 3'b001) || (func3_q == 3'b100) ||
                 (func3_q == 3'b110);
    div_zero_s = is_div_s && (b_q == ZERO_X);
    div_ovf_s  = is_div_s && !func3_q[0] && (a_q == MIN_NEG) && (b_q == ALL_ONES);
    special_s  = div_zero_s || div_ovf_s;
    if (a_signed_s && a_q[XLEN-1]) begin
      mag_a_s = ZERO_X - a_q;
    end else begin
      mag_a_s = a_q;
    end
    if (b_signed_s && b_q[XLEN-1]) begin
      mag_b_s = ZERO_X - b_q;
    end else begin
      mag_b_s = b_q;
    end
  end

  // One CALC step for each operation: shift-add multiply, restoring divide
  always_comb begin
    mul_sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                 {1'b0, (acc_q[0] ? mcand_q : ZERO_X)};
    mul_next_s = {mul_sum_s, acc_q[XLEN-1:1]};
    // The shifted remainder needs XLEN+1 bits before the trial subtract.
    rem_sh_s   = acc_q[2*XLEN-1:XLEN-1];
    div_ge_s   = (rem_sh_s >= {1'b0, mcand_q});
    div_sub_s  = rem_sh_s[XLEN-1:0] - mcand_q;
    if (div_ge_s) begin
      div_next_s = {div_sub_s, acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_next_s = {rem_sh_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up and result selection, with the special-case override
  always_comb begin
    if (neg_a_q ^ neg_b_q) begin
      prod_fix_s = {(2*XLEN){1'b0}} - acc_q;
      quot_fix_s = ZERO_X - acc_q[XLEN-1:0];
    end else begin
      prod_fix_s = acc_q;
      quot_fix_s = acc_q[XLEN-1:0];
    end
    if (neg_a_q) begin
      rem_fix_s = ZERO_X - acc_q[2*XLEN-1:XLEN];
    end else begin
      rem_fix_s = acc_q[2*XLEN-1:XLEN];
    end
    case (func3_q)
      3'b000:                 fix_res_s = prod_fix_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res_s = prod_fix_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res_s = quot_fix_s;
      3'b110, 3'b111:         fix_res_s = rem_fix_s;
      default:                fix_res_s = ZERO_X;
    endcase
    if (special_s) begin
      fix_res_s = special_result(func3_q[1], div_zero_s, a_q);
    end else begin
      fix_res_s = fix_res_s;
    end
  end

  // Next-state and datapath update for the sequencer
  always_comb begin
    state_d  = state_q;
    func3_d  = func3_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          func3_d = func3;
          a_d     = op_a;
          b_d     = op_b;
          state_d = S_PREP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          neg_a_d = a_signed_s && a_q[XLEN-1];
          neg_b_d = b_signed_s && b_q[XLEN-1];
          cnt_d   = {CW{1'b0}};
          if (is_div_s) begin
            acc_d   = {ZERO_X, mag_a_s};
            mcand_d = mag_b_s;
          end else begin
            acc_d   = {ZERO_X, mag_b_s};
            mcand_d = mag_a_s;
          end
          if (FAST_SPECIAL && special_s) begin
            result_d = special_result(func3_q[1], div_zero_s, a_q);
            state_d  = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_s ? div_next_s : mul_next_s;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res_s;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      func3_q  <= 3'b000;
      a_q      <= ZERO_X;
      b_q      <= ZERO_X;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      mcand_q  <= ZERO_X;
      acc_q    <= {(2*XLEN){1'b0}};
      cnt_q    <= {CW{1'b0}};
      result_q <= ZERO_X;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      func3_q  <= func3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq, run with XLEN=32 and FAST_SPECIAL=1.
// Expected results come from a 64-bit arithmetic model of the RV32M rules.
module tb_mdu_seq;

  localparam bit FAST = 1'b1;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  func3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total;
  int bad;
  logic [31:0] last_res;

  mdu_seq #(.XLEN(32), .FAST_SPECIAL(FAST)) dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard watchdog so the run can never hang
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'd0) ||
           ((f == 3'b100 || f == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference model: plain 64-bit arithmetic following the RV32M rules
  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'(ub); return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb; return p[31:0];
      end
      3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Issue one op, optionally scramble inputs/start while busy, check all
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit scramble);
    logic [31:0] exp;
    int exp_lat;
    int n;
    int bcnt;
    exp     = ref_mdu(f, a, b);
    exp_lat = (FAST && is_special(f, a, b)) ? 1 : 34;
    @(negedge clk);
    func3 = f; op_a = a; op_b = b; start = 1'b1; flush = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    bcnt = 0;
    while (!done && n < 200) begin
      if (busy) bcnt++;
      if (scramble) begin
        op_a  = $urandom;
        op_b  = $urandom;
        func3 = 3'($urandom_range(0, 7));
        start = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
    end
    if (busy) bcnt++;
    start = 1'b0;
    chk("latency", n, exp_lat);
    chk("result", result, exp);
    chk("busy_cycles", bcnt, exp_lat + 1);
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("idle_after", {31'd0, busy}, 32'd0);
    chk("result_hold", result, exp);
    last_res = exp;
  endtask

  // Count done pulses over a window of cycles
  task automatic no_done_window(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    int n;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    total = 0; bad = 0; last_res = 32'd0;
    rst = 1'b1; start = 1'b0; flush = 1'b0; func3 = 3'b000; op_a = 32'd0; op_b = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    rst = 1'b0;

    // Directed cases
    run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'b101, 32'd100, 32'd7, 1'b0);
    run_op(3'b111, 32'd100, 32'd7, 1'b0);
    run_op(3'b101, 32'd5, 32'd0, 1'b0);
    run_op(3'b110, 32'd5, 32'd0, 1'b0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Flush in CALC: no done, idle next cycle, result unchanged
    @(negedge clk);
    func3 = 3'b100; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_done", {31'd0, done}, 32'd0);
    chk("flush_result", result, last_res);
    no_done_window("flush_no_done", 40);

    // Start pulsed while busy: ignored, exactly one done
    run_op(3'b101, 32'd12345, 32'd67, 1'b1);
    no_done_window("single_done", 40);

    // Reset mid-CALC clears everything
    @(negedge clk);
    func3 = 3'b000; op_a = 32'd9; op_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    last_res = 32'd0;
    no_done_window("midrst_no_done", 40);

    // start with flush in IDLE is not accepted
    start = 1'b1; flush = 1'b1; func3 = 3'b000; op_a = 32'd2; op_b = 32'd2;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("startflush_busy", {31'd0, busy}, 32'd0);
    no_done_window("startflush_no_done", 40);
    chk("startflush_result", result, last_res);

    // Back-to-back with start held: second op accepted the cycle after done
    func3 = 3'b000; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
    @(negedge clk);
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_lat1", n, 34);
    chk("b2b_res1", result, 32'd15);
    @(negedge clk);
    chk("b2b_gap_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("b2b_accept2", {31'd0, busy}, 32'd1);
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_lat2", n, 34);
    chk("b2b_res2", result, 32'd15);
    last_res = 32'd15;

    // Randomized ops with inputs scrambled while busy
    for (int k = 0; k < 40; k++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 300));
        3: ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 50));
        default: ra = ra;
      endcase
      run_op(rf, ra, rb, (k % 2) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
